// File: rtl/uart_receive.sv
// UART receiver: synchronised rx, mid-bit sampling, LSB-first deserialisation,
// valid/ready output with one-cycle framing-error and overrun pulses.
module uart_receive #(
    parameter int d_width      = 4,
    parameter int clks_per_bit = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);
    localparam int            iw       = (d_width > 1) ? $clog2(d_width) : 1;
    localparam logic [3:0]    bit_last = 4'(clks_per_bit - 1);
    localparam logic [3:0]    half_cnt = 4'((clks_per_bit - 1) / 2);
    localparam logic [iw-1:0] idx_last = iw'(d_width - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    logic               rst_meta_r;
    logic               rst_n_r;
    logic               rx_meta_r;
    logic               rx_sync_r;
    state_t             state_r;
    state_t             state_s;
    logic [3:0]         timer_r;
    logic [3:0]         timer_s;
    logic [iw-1:0]      idx_r;
    logic [iw-1:0]      idx_s;
    logic [d_width-1:0] shift_r;
    logic [d_width-1:0] shift_s;
    logic               done_r;
    logic               done_s;
    logic               ferr_s;

    // Reset asserts at once and releases two clocks after rst goes high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_r <= 1'b0;
            rst_n_r    <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_n_r    <= rst_meta_r;
        end
    end

    // Next-state, bit timer and shift register logic
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        done_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // With no half-bit offset the detection cycle is the start sample
                if (!rx_sync_r) begin
                    if (half_cnt == 4'd0) begin
                        state_s = DATA;
                        timer_s = bit_last;
                        idx_s   = '0;
                    end else begin
                        state_s = START;
                        timer_s = half_cnt - 4'd1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (timer_r == 4'd0) begin
                    if (!rx_sync_r) begin
                        state_s = DATA;
                        timer_s = bit_last;
                        idx_s   = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    timer_s = timer_r - 4'd1;
                end
            end
            DATA: begin
                if (timer_r == 4'd0) begin
                    shift_s[idx_r] = rx_sync_r;
                    timer_s        = bit_last;
                    if (idx_r == idx_last) begin
                        state_s = STOP;
                    end else begin
                        idx_s = idx_r + iw'(1);
                    end
                end else begin
                    timer_s = timer_r - 4'd1;
                end
            end
            STOP: begin
                if (timer_r == 4'd0) begin
                    if (rx_sync_r) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = BREAK;
                    end
                end else begin
                    timer_s = timer_r - 4'd1;
                end
            end
            BREAK: begin
                if (rx_sync_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Synchroniser, FSM state and status registers
    always_ff @(posedge clk or negedge rst_n_r) begin
        if (!rst_n_r) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            state_r   <= IDLE;
            timer_r   <= 4'd0;
            idx_r     <= '0;
            shift_r   <= '0;
            done_r    <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            state_r   <= state_s;
            timer_r   <= timer_s;
            idx_r     <= idx_s;
            shift_r   <= shift_s;
            done_r    <= done_s;
            rx_busy   <= (state_s != IDLE);
            frame_err <= ferr_s;
        end
    end

    // Output word register and valid/ready handshake with overrun detection
    always_ff @(posedge clk or negedge rst_n_r) begin
        if (!rst_n_r) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_r) begin
                rx_data  <= shift_r;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end
endmodule
